sr_flag_bank: RTL and testbench

//  Clocked, parametrised successor to the single NOR set/reset latch: WIDTH independent

---
 rtl/sr_flag_pkg.sv | 22 ++
 rtl/sr_cell.sv | 40 ++++
 rtl/sr_flag_bank.sv | 80 ++++++++
 tb/tb_sr_flag_bank.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sr_flag_pkg : collision-mode encodings and popcount helper for the bank   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package sr_flag_pkg;

  localparam int MODE_RDOM   = 0;
  localparam int MODE_SDOM   = 1;
  localparam int MODE_TOGGLE = 2;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sr_cell : next-state logic for one flag bit with selectable collision    |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module sr_cell
  import sr_flag_pkg::*;
#(
  parameter int MODE = MODE_RDOM
) (
  input  logic se,
  input  logic r,
  input  logic clr,
  input  logic rdclr,
  input  logic q,
  output logic q_next
);

  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = 1'b0;
    end else if (se && r) begin
      case (MODE)
        MODE_SDOM:   q_next = 1'b1;
        MODE_TOGGLE: q_next = ~q;
        default:     q_next = 1'b0;
      endcase
    end else if (se) begin
      q_next = 1'b1;
    end else if (r) begin
      q_next = 1'b0;
    end else if (rdclr && q) begin
      // Read-clear has lowest priority so a same-cycle set survives the read.
      q_next = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sr_flag_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sr_flag_bank : WIDTH synchronous SR flags with read-and-clear snapshot   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module sr_flag_bank
  import sr_flag_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               MODE      = MODE_RDOM,
  parameter int               EDGE_SET  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_all,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_l,
  output logic             any_set,
  output logic [CW-1:0]    count
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sr_flag_bank: WIDTH must be in 1..32");
  end
  if (MODE < MODE_RDOM || MODE > MODE_TOGGLE) begin : g_bad_mode
    $error("sr_flag_bank: MODE must be 0, 1 or 2");
  end
  if (EDGE_SET < 0 || EDGE_SET > 1) begin : g_bad_edge
    $error("sr_flag_bank: EDGE_SET must be 0 or 1");
  end

  logic [WIDTH-1:0] s_prev;
  logic [WIDTH-1:0] se;
  logic [WIDTH-1:0] q_next;

  assign se = (EDGE_SET != 0) ? (s & ~s_prev) : s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE(MODE)
    ) u_cell (
      .se    (se[i]),
      .r     (r[i]),
      .clr   (clr_all),
      .rdclr (rd_req),
      .q     (q[i]),
      .q_next(q_next[i])
    );
  end

  // s_prev resets to all-ones so a set held through reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= RESET_VAL;
      s_prev  <= '1;
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      q      <= q_next;
      s_prev <= s;
      rd_ack <= rd_req;
      if (rd_req) begin
        rd_data <= q;
      end
    end
  end

  assign q_l     = ~q;
  assign any_set = |q;
  assign count   = CW'(popcount(32'(q)));

endmodule
`default_nettype wire

// File: tb/tb_sr_flag_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sr_flag_bank : directed checks of three sr_flag_bank configurations   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_sr_flag_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // a: MODE0 level set, RESET_VAL A5; b: MODE1 level set; c: MODE2 edge set
  logic [7:0] s_a, r_a, s_b, r_b, s_c, r_c;
  logic       clr_a, clr_b, clr_c, rd_a, rd_b, rd_c;
  logic       ack_a, ack_b, ack_c, any_a, any_b, any_c;
  logic [7:0] rdd_a, rdd_b, rdd_c, q_a, q_b, q_c, ql_a, ql_b, ql_c;
  logic [3:0] cnt_a, cnt_b, cnt_c;

  sr_flag_bank #(.WIDTH(8), .MODE(0), .EDGE_SET(0), .RESET_VAL(8'hA5)) u_a (
    .clk(clk), .rst(rst), .s(s_a), .r(r_a), .clr_all(clr_a), .rd_req(rd_a),
    .rd_ack(ack_a), .rd_data(rdd_a), .q(q_a), .q_l(ql_a), .any_set(any_a), .count(cnt_a));

  sr_flag_bank #(.WIDTH(8), .MODE(1), .EDGE_SET(0), .RESET_VAL(8'h00)) u_b (
    .clk(clk), .rst(rst), .s(s_b), .r(r_b), .clr_all(clr_b), .rd_req(rd_b),
    .rd_ack(ack_b), .rd_data(rdd_b), .q(q_b), .q_l(ql_b), .any_set(any_b), .count(cnt_b));

  sr_flag_bank #(.WIDTH(8), .MODE(2), .EDGE_SET(1), .RESET_VAL(8'h00)) u_c (
    .clk(clk), .rst(rst), .s(s_c), .r(r_c), .clr_all(clr_c), .rd_req(rd_c),
    .rd_ack(ack_c), .rd_data(rdd_c), .q(q_c), .q_l(ql_c), .any_set(any_c), .count(cnt_c));

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {s_a, r_a, s_b, r_b, s_c, r_c} = '0;
    {clr_a, clr_b, clr_c, rd_a, rd_b, rd_c} = '0;
    step();
    chk("rst_q_a",     q_a,   8'hA5);
    chk("rst_ql_a",    ql_a,  8'h5A);
    chk("rst_count_a", cnt_a, 4);
    chk("rst_ack_a",   ack_a, 0);
    chk("rst_rdd_a",   rdd_a, 8'h00);
    chk("rst_any_a",   any_a, 1);
    chk("rst_q_c",     q_c,   8'h00);
    rst = 1'b0;
    step();

    // Collisions: clear a, collide on b, load 03 into c
    clr_a = 1'b1;
    s_b = 8'h0F; r_b = 8'h0F;
    s_c = 8'h03;
    step();
    chk("clr_q_a",      q_a, 8'h00);
    chk("coll_sdom_q",  q_b, 8'h0F);
    chk("coll_sdom_ql", ql_b, 8'hF0);
    chk("load_q_c",     q_c, 8'h03);
    clr_a = 1'b0; s_a = 8'h0F; r_a = 8'h0F;
    s_b = 8'h00; r_b = 8'h00;
    s_c = 8'h00;
    step();
    chk("coll_rdom_q",  q_a, 8'h00);
    chk("coll_rdom_any", any_a, 0);
    s_a = 8'h00; r_a = 8'h00;
    s_c = 8'h0F; r_c = 8'h0F;
    step();
    chk("coll_tog_q",     q_c, 8'h0C);
    chk("coll_tog_count", cnt_c, 2);
    s_c = 8'h00; r_c = 8'h00;
    step();

    // Edge set: s[0] held 5 cycles, r[0] pulsed in cycle 3
    clr_c = 1'b1;
    step();
    clr_c = 1'b0;
    chk("edge_clr_q", q_c, 8'h00);
    s_c = 8'h01;
    step();
    chk("edge_c1_q", q_c, 8'h01);
    step();
    chk("edge_c2_q", q_c, 8'h01);
    r_c = 8'h01;
    step();
    chk("edge_c3_q", q_c, 8'h00);
    r_c = 8'h00;
    step();
    chk("edge_c4_q", q_c, 8'h00);
    rd_a = 1'b1;
    step();
    chk("edge_c5_q", q_c, 8'h00);
    chk("midrd_ack_a", ack_a, 1);

    // Asynchronous reset in the middle of a read, s_c still high
    rst = 1'b1;
    #1;
    chk("async_ack_a",   ack_a, 0);
    chk("async_q_a",     q_a,   8'hA5);
    chk("async_ql_a",    ql_a,  8'h5A);
    chk("async_count_a", cnt_a, 4);
    rd_a = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
    step();
    chk("edge_rstrel_q", q_c, 8'h00);
    chk("rstrel_ack_a",  ack_a, 0);
    s_c = 8'h00;

    // Read-clear race
    clr_a = 1'b1;
    step();
    clr_a = 1'b0; s_a = 8'h81;
    step();
    chk("race_pre_q", q_a, 8'h81);
    chk("race_pre_count", cnt_a, 2);
    s_a = 8'h01; rd_a = 1'b1;
    step();
    chk("race1_ack", ack_a, 1);
    chk("race1_rdd", rdd_a, 8'h81);
    chk("race1_q",   q_a,   8'h01);
    s_a = 8'h00;
    step();
    chk("race2_ack", ack_a, 1);
    chk("race2_rdd", rdd_a, 8'h01);
    chk("race2_q",   q_a,   8'h00);
    rd_a = 1'b0;
    step();
    chk("race_idle_ack", ack_a, 0);
    chk("race_hold_rdd", rdd_a, 8'h01);

    // Back-to-back reads with an event arriving mid-burst
    s_a = 8'h03;
    step();
    s_a = 8'h00; rd_a = 1'b1;
    step();
    chk("b2b1_ack", ack_a, 1);
    chk("b2b1_rdd", rdd_a, 8'h03);
    acc = rdd_a;
    s_a = 8'h10;
    step();
    chk("b2b2_ack", ack_a, 1);
    chk("b2b2_rdd", rdd_a, 8'h00);
    chk("b2b2_q",   q_a,   8'h10);
    acc = acc | rdd_a;
    s_a = 8'h00;
    step();
    chk("b2b3_ack", ack_a, 1);
    chk("b2b3_rdd", rdd_a, 8'h10);
    chk("b2b3_disj", acc & rdd_a, 8'h00);
    acc = acc | rdd_a;
    chk("b2b_union", acc, 8'h13);
    rd_a = 1'b0;
    step();
    chk("b2b_end_ack", ack_a, 0);
    chk("b2b_end_q",   q_a,   8'h00);

    // clr_all with set and read in the same cycle
    s_a = 8'h3C;
    step();
    chk("clr_pre_q", q_a, 8'h3C);
    s_a = 8'hFF; clr_a = 1'b1; rd_a = 1'b1;
    step();
    chk("clr_q",     q_a,   8'h00);
    chk("clr_ql",    ql_a,  8'hFF);
    chk("clr_rdd",   rdd_a, 8'h3C);
    chk("clr_ack",   ack_a, 1);
    chk("clr_any",   any_a, 0);
    chk("clr_count", cnt_a, 0);
    s_a = 8'h00; clr_a = 1'b0; rd_a = 1'b0;
    step();
    chk("clr_after_q",   q_a,   8'h00);
    chk("clr_after_ack", ack_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
